// File: rtl/cache_sim_pkg.sv
// Package for the cache simulator engine.
// Holds the FSM state encoding, the derived-width helpers used to size the
// tag/set/offset fields and LRU ages, and the saturating counter update.
package cache_sim_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      UPDATE = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   function automatic int off_w(input int line_size);
      return $clog2(line_size);
   endfunction

   // A fully associative cache has a single set, so the index width is 0.
   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_w, input int line_size, input int sets);
      return addr_w - off_w(line_size) - idx_w(sets);
   endfunction

   // A direct-mapped cache still keeps a 1-bit (constant 0) age field.
   function automatic int age_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   // Adds inc to v and clamps the result at the all-ones value of a w-bit counter.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] inc,
                                           input int w);
      logic [63:0] mask;
      logic [63:0] sum;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      sum  = v + inc;
      if ((sum > mask) || (sum < v)) return mask;
      return sum;
   endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age update for one cache set (combinational).
// Ports:
//   age_in   per-way ages of the set (a permutation of 0..WAYS-1)
//   touch    way being hit or filled
//   age_out  ages after the touch: the touched way becomes the most recent
//            (WAYS-1), and every way that was younger moves down by one
//   victim   way whose age is 0 (least recently used)
module cache_lru_set #(
   parameter int WAYS  = 8,
   parameter int AGE_W = 3
) (
   input  logic [WAYS-1:0][AGE_W-1:0] age_in,
   input  logic [AGE_W-1:0]           touch,
   output logic [WAYS-1:0][AGE_W-1:0] age_out,
   output logic [AGE_W-1:0]           victim
);

   always_comb begin
      age_out = age_in;
      victim  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_in[w] == '0) victim = AGE_W'(w);
         if (age_in[w] > age_in[touch]) age_out[w] = age_in[w] - 1'b1;
      end
      age_out[touch] = AGE_W'(WAYS - 1);
   end

endmodule

// File: rtl/cache_sim_engine.sv
// Set-associative cache simulator: tags only, no data storage.
// Each accepted request is looked up and the cache state is updated. The
// result comes back on a response pulse 2 cycles after acceptance. Hit, miss
// and eviction counts are kept in saturating counters.
// Optional feature: define CACHE_SIM_WB_EN to track per-line dirty bits and
// count dirty evictions and dirty lines flushed on Writeback_10.
// Ports:
//   Clock_10, Reset_10            clock, async active-low reset
//   Req_Valid_10/Req_Ready_10     request handshake (ready only in IDLE without flush)
//   Req_Addr_10, Req_Write_10     byte address, store flag
//   Flush_10                      invalidate the whole cache, one set per cycle
//   Resp_Valid_10/Hit_10/Evict_10 per-request result pulse
//   Busy_10                       engine not idle
//   CacheHit_10, CacheMiss_10, Evict_10, Writeback_10   statistics
module cache_sim_engine
   import cache_sim_pkg::*;
#(
   parameter int ADDR_W     = 31,
   parameter int CACHE_SIZE = 1024,
   parameter int LINE_SIZE  = 32,
   parameter int WAYS       = 8,
   parameter int CNT_W      = 32
) (
   input  logic              Clock_10,
   input  logic              Reset_10,
   input  logic              Req_Valid_10,
   output logic              Req_Ready_10,
   input  logic [ADDR_W-1:0] Req_Addr_10,
   input  logic              Req_Write_10,
   input  logic              Flush_10,
   output logic              Resp_Valid_10,
   output logic              Resp_Hit_10,
   output logic              Resp_Evict_10,
   output logic              Busy_10,
   output logic [CNT_W-1:0]  CacheHit_10,
   output logic [CNT_W-1:0]  CacheMiss_10,
   output logic [CNT_W-1:0]  Evict_10,
   output logic [CNT_W-1:0]  Writeback_10
);

   localparam int LINES = CACHE_SIZE / LINE_SIZE;
   localparam int SETS  = LINES / WAYS;
   localparam int OFF_W = off_w(LINE_SIZE);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, LINE_SIZE, SETS);
   localparam int AGE_W = age_w(WAYS);
   localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;

   state_t                             state_q;
   logic [ADDR_W-1:0]                  addr_q;
   logic                               wr_q;
   logic [SET_W-1:0]                   flush_set_q;
   logic [SETS-1:0][WAYS-1:0]          valid_q;
   logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q;
   logic [TAG_W-1:0]                   tag_mem [SETS][WAYS];

   logic [TAG_W-1:0]                   req_tag;
   logic [SET_W-1:0]                   req_set;
   logic [WAYS-1:0]                    hit_vec;
   logic [AGE_W-1:0]                   hit_way;
   logic [AGE_W-1:0]                   victim;
   logic [AGE_W-1:0]                   touch;
   logic [WAYS-1:0][AGE_W-1:0]         age_new;
   logic                               hit;
   logic                               victim_valid;

   assign req_tag = addr_q[ADDR_W-1 -: TAG_W];
   generate
      if (IDX_W > 0) begin : g_idx
         assign req_set = addr_q[OFF_W +: IDX_W];
      end else begin : g_noidx
         assign req_set = '0;
      end
   endgenerate

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_set][w] && (tag_mem[req_set][w] == req_tag)) begin
            hit_vec[w] = 1'b1;
            hit_way    = AGE_W'(w);
         end
      end
   end

   assign hit          = |hit_vec;
   assign touch        = hit ? hit_way : victim;
   assign victim_valid = valid_q[req_set][victim];

   cache_lru_set #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
      .age_in  (age_q[req_set]),
      .touch   (touch),
      .age_out (age_new),
      .victim  (victim)
   );

   assign Req_Ready_10 = (state_q == IDLE) && !Flush_10;
   assign Busy_10      = (state_q != IDLE);

   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic [63:0] inc);
      logic [63:0] t;
      t = sat_inc(64'(c), inc, CNT_W);
      return t[CNT_W-1:0];
   endfunction

`ifdef CACHE_SIM_WB_EN
   logic [SETS-1:0][WAYS-1:0] dirty_q;
   logic [63:0]               flush_wb;
   logic                      victim_dirty;
   assign flush_wb     = 64'($countones(valid_q[flush_set_q] & dirty_q[flush_set_q]));
   assign victim_dirty = dirty_q[req_set][victim];
`endif

   // Tags carry no reset: valid bits qualify every read.
   always_ff @(posedge Clock_10) begin
      if ((state_q == LOOKUP) && !hit) tag_mem[req_set][victim] <= req_tag;
   end

   always_ff @(posedge Clock_10 or negedge Reset_10) begin
      if (!Reset_10) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         wr_q          <= 1'b0;
         flush_set_q   <= '0;
         valid_q       <= '0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age_q[s][w] <= AGE_W'(w);
         Resp_Valid_10 <= 1'b0;
         Resp_Hit_10   <= 1'b0;
         Resp_Evict_10 <= 1'b0;
         CacheHit_10   <= '0;
         CacheMiss_10  <= '0;
         Evict_10      <= '0;
         Writeback_10  <= '0;
`ifdef CACHE_SIM_WB_EN
         dirty_q       <= '0;
`endif
      end else begin
         Resp_Valid_10 <= 1'b0;
         Resp_Hit_10   <= 1'b0;
         Resp_Evict_10 <= 1'b0;
         case (state_q)
            IDLE: begin
               // Flush takes priority over a request in the same cycle.
               if (Flush_10) begin
                  state_q     <= FLUSH;
                  flush_set_q <= '0;
               end else if (Req_Valid_10) begin
                  addr_q  <= Req_Addr_10;
                  wr_q    <= Req_Write_10;
                  state_q <= LOOKUP;
               end
            end
            LOOKUP: begin
               // State and counters commit here so the response and the
               // updated statistics appear together in the UPDATE cycle.
               Resp_Valid_10  <= 1'b1;
               Resp_Hit_10    <= hit;
               Resp_Evict_10  <= !hit && victim_valid;
               age_q[req_set] <= age_new;
               if (hit) begin
                  CacheHit_10 <= bump(CacheHit_10, 64'd1);
`ifdef CACHE_SIM_WB_EN
                  if (wr_q) dirty_q[req_set][hit_way] <= 1'b1;
`endif
               end else begin
                  CacheMiss_10             <= bump(CacheMiss_10, 64'd1);
                  valid_q[req_set][victim] <= 1'b1;
                  if (victim_valid) Evict_10 <= bump(Evict_10, 64'd1);
`ifdef CACHE_SIM_WB_EN
                  dirty_q[req_set][victim] <= wr_q;
                  if (victim_valid && victim_dirty) Writeback_10 <= bump(Writeback_10, 64'd1);
`endif
               end
               state_q <= UPDATE;
            end
            UPDATE: state_q <= IDLE;
            FLUSH: begin
               valid_q[flush_set_q] <= '0;
               for (int w = 0; w < WAYS; w++)
                  age_q[flush_set_q][w] <= AGE_W'(w);
`ifdef CACHE_SIM_WB_EN
               dirty_q[flush_set_q] <= '0;
               Writeback_10         <= bump(Writeback_10, flush_wb);
`endif
               if (flush_set_q == SET_W'(SETS - 1)) state_q <= IDLE;
               else flush_set_q <= flush_set_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Offset bits are never examined; the store flag matters only with dirty tracking.
   logic unused_ok;
   assign unused_ok = &{1'b0, addr_q[OFF_W-1:0], wr_q};

endmodule

// File: tb/tb_cache_sim_engine.sv
// Self-checking bench for cache_sim_engine (default parameters).
// The reference keeps, per set, the resident tags ordered from least to most
// recently used; a miss on a full set evicts the oldest entry.
module tb_cache_sim_engine;

   localparam int ADDR_W = 31;
   localparam int SETS   = 4;
   localparam int WAYS   = 8;
   localparam int CNT_W  = 32;

   logic              Clock_10 = 1'b0;
   logic              Reset_10;
   logic              Req_Valid_10;
   logic              Req_Ready_10;
   logic [ADDR_W-1:0] Req_Addr_10;
   logic              Req_Write_10;
   logic              Flush_10;
   logic              Resp_Valid_10;
   logic              Resp_Hit_10;
   logic              Resp_Evict_10;
   logic              Busy_10;
   logic [CNT_W-1:0]  CacheHit_10;
   logic [CNT_W-1:0]  CacheMiss_10;
   logic [CNT_W-1:0]  Evict_10;
   logic [CNT_W-1:0]  Writeback_10;

   cache_sim_engine u_dut (
      .Clock_10      (Clock_10),
      .Reset_10      (Reset_10),
      .Req_Valid_10  (Req_Valid_10),
      .Req_Ready_10  (Req_Ready_10),
      .Req_Addr_10   (Req_Addr_10),
      .Req_Write_10  (Req_Write_10),
      .Flush_10      (Flush_10),
      .Resp_Valid_10 (Resp_Valid_10),
      .Resp_Hit_10   (Resp_Hit_10),
      .Resp_Evict_10 (Resp_Evict_10),
      .Busy_10       (Busy_10),
      .CacheHit_10   (CacheHit_10),
      .CacheMiss_10  (CacheMiss_10),
      .Evict_10      (Evict_10),
      .Writeback_10  (Writeback_10)
   );

   always #5 Clock_10 = ~Clock_10;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int unsigned m_tag   [SETS][WAYS];
   bit          m_dirty [SETS][WAYS];
   int          m_n     [SETS];
   logic [63:0] e_hit, e_miss, e_ev, e_wb;
   logic        last_hit, last_ev;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) m_n[s] = 0;
      e_hit = 0; e_miss = 0; e_ev = 0; e_wb = 0;
   endtask

   task automatic model_flush();
      for (int s = 0; s < SETS; s++) begin
`ifdef CACHE_SIM_WB_EN
         for (int i = 0; i < m_n[s]; i++) if (m_dirty[s][i]) e_wb++;
`endif
         m_n[s] = 0;
      end
   endtask

   task automatic model_access(input logic [ADDR_W-1:0] a, input logic w,
                               output logic h, output logic ev);
      int s, pos;
      int unsigned t;
      bit d;
      s   = int'(a[6:5]);
      t   = {8'd0, a[30:7]};
      pos = -1;
      for (int i = 0; i < m_n[s]; i++) if (m_tag[s][i] == t) pos = i;
      ev = 1'b0;
      if (pos >= 0) begin
         h = 1'b1; e_hit++;
         d = m_dirty[s][pos] | w;
         for (int i = pos; i < m_n[s] - 1; i++) begin
            m_tag[s][i] = m_tag[s][i+1]; m_dirty[s][i] = m_dirty[s][i+1];
         end
         m_tag[s][m_n[s]-1] = t; m_dirty[s][m_n[s]-1] = d;
      end else begin
         h = 1'b0; e_miss++;
         if (m_n[s] == WAYS) begin
            ev = 1'b1; e_ev++;
`ifdef CACHE_SIM_WB_EN
            if (m_dirty[s][0]) e_wb++;
`endif
            for (int i = 0; i < WAYS - 1; i++) begin
               m_tag[s][i] = m_tag[s][i+1]; m_dirty[s][i] = m_dirty[s][i+1];
            end
            m_n[s]--;
         end
         m_tag[s][m_n[s]] = t; m_dirty[s][m_n[s]] = w; m_n[s]++;
      end
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_hitcnt"},  64'(CacheHit_10),  e_hit);
      chk({tag, "_misscnt"}, 64'(CacheMiss_10), e_miss);
      chk({tag, "_evcnt"},   64'(Evict_10),     e_ev);
      chk({tag, "_wbcnt"},   64'(Writeback_10), e_wb);
   endtask

   // ---------------- stimulus tasks ----------------
   task automatic do_req(input logic [ADDR_W-1:0] a, input logic w);
      logic h, ev;
      int guard;
      @(negedge Clock_10);
      Req_Valid_10 = 1'b1; Req_Addr_10 = a; Req_Write_10 = w;
      guard = 0;
      while (!Req_Ready_10 && guard < 50) begin
         @(negedge Clock_10); guard++;
      end
      if (!Req_Ready_10) begin
         chk("ready_timeout", 64'd0, 64'd1);
         Req_Valid_10 = 1'b0;
         return;
      end
      model_access(a, w, h, ev);
      @(posedge Clock_10); #1;
      Req_Valid_10 = 1'b0;
      chk("resp_early", 64'(Resp_Valid_10), 64'd0);
      chk("busy_lookup", 64'(Busy_10), 64'd1);
      @(posedge Clock_10); #1;
      chk("resp_valid", 64'(Resp_Valid_10), 64'd1);
      chk("resp_hit", 64'(Resp_Hit_10), 64'(h));
      chk("resp_evict", 64'(Resp_Evict_10), 64'(ev));
      last_hit = Resp_Hit_10; last_ev = Resp_Evict_10;
      chk_counters("req");
      @(posedge Clock_10); #1;
      chk("resp_pulse", 64'(Resp_Valid_10), 64'd0);
   endtask

   task automatic flush_op(input logic with_req);
      int n;
      @(negedge Clock_10);
      Flush_10 = 1'b1; Req_Valid_10 = with_req; Req_Addr_10 = ADDR_W'($urandom);
      #1;
      chk("flush_ready_low", 64'(Req_Ready_10), 64'd0);
      @(posedge Clock_10); #1;
      Flush_10 = 1'b0; Req_Valid_10 = 1'b0;
      n = 0;
      while (Busy_10 && n < 50) begin
         @(posedge Clock_10); #1; n++;
      end
      chk("flush_busy_cycles", 64'(n), 64'(SETS));
      chk("flush_no_resp", 64'(Resp_Valid_10), 64'd0);
      model_flush();
      chk_counters("flush");
   endtask

   function automatic logic [ADDR_W-1:0] mk_addr(input int tag, input int set, input int off);
      return {24'(tag), 2'(set), 5'(off)};
   endfunction

   logic [63:0] wb0;

   initial begin
      Reset_10 = 1'b0; Req_Valid_10 = 1'b0; Req_Addr_10 = '0;
      Req_Write_10 = 1'b0; Flush_10 = 1'b0;
      model_reset();
      repeat (3) @(posedge Clock_10);
      #1;
      chk("rst_ready", 64'(Req_Ready_10), 64'd1);
      chk("rst_busy", 64'(Busy_10), 64'd0);
      chk("rst_resp", 64'(Resp_Valid_10), 64'd0);
      chk_counters("rst");
      @(negedge Clock_10); Reset_10 = 1'b1;

      // miss then hit on the same address
      do_req(31'h0, 1'b0);
      chk("t1_first_miss", 64'(last_hit), 64'd0);
      do_req(31'h0, 1'b0);
      chk("t1_second_hit", 64'(last_hit), 64'd1);
      chk("t1_misscnt", 64'(CacheMiss_10), 64'd1);
      chk("t1_hitcnt", 64'(CacheHit_10), 64'd1);

      // fill set 0 past capacity: the 9th line evicts address 0
      for (int k = 1; k <= 8; k++) do_req(ADDR_W'(k * 128), 1'b0);
      chk("t2_evict_flag", 64'(last_ev), 64'd1);
      chk("t2_evcnt", 64'(Evict_10), 64'd1);
      do_req(31'h0, 1'b0);
      chk("t2_readd0_miss", 64'(last_hit), 64'd0);

      // LRU ordering after a re-touch
      flush_op(1'b0);
      for (int k = 0; k < 8; k++) do_req(ADDR_W'(k * 128), 1'b0);
      do_req(31'h0, 1'b0);
      do_req(ADDR_W'(8 * 128), 1'b0);
      do_req(31'h0, 1'b0);
      chk("t3_addr0_survives", 64'(last_hit), 64'd1);
      do_req(ADDR_W'(128), 1'b0);
      chk("t3_addr128_evicted", 64'(last_hit), 64'd0);

      // flush wins over a simultaneous request
      flush_op(1'b1);
      do_req(31'h0, 1'b0);
      chk("t4_after_flush_miss", 64'(last_hit), 64'd0);

      // dirty line eviction
      flush_op(1'b0);
      wb0 = e_wb;
      do_req(31'h0, 1'b1);
      for (int k = 1; k <= 8; k++) do_req(ADDR_W'(k * 128), 1'b0);
`ifdef CACHE_SIM_WB_EN
      chk("t6_writeback", 64'(Writeback_10), wb0 + 64'd1);
`else
      chk("t6_writeback", 64'(Writeback_10), 64'd0);
`endif

      // randomized traffic with occasional flushes
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 24) == 0) flush_op(1'($urandom_range(0, 1)));
         else do_req(mk_addr($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 31)),
                     1'($urandom_range(0, 1)));
      end

      // reset during LOOKUP drops the request
      @(negedge Clock_10);
      Req_Valid_10 = 1'b1; Req_Addr_10 = '0; Req_Write_10 = 1'b0;
      @(posedge Clock_10); #1;
      Req_Valid_10 = 1'b0;
      chk("t5_in_lookup", 64'(Busy_10), 64'd1);
      Reset_10 = 1'b0;
      #1;
      model_reset();
      chk("t5_ready_async", 64'(Req_Ready_10), 64'd1);
      chk("t5_busy_async", 64'(Busy_10), 64'd0);
      chk_counters("t5");
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock_10); #1;
         chk("t5_no_resp", 64'(Resp_Valid_10), 64'd0);
      end
      @(negedge Clock_10); Reset_10 = 1'b1;
      @(posedge Clock_10); #1;
      chk("t5_no_resp_after", 64'(Resp_Valid_10), 64'd0);
      do_req(31'h0, 1'b0);
      chk("t5_cold_miss", 64'(last_hit), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
      $fatal(1);
   end

endmodule
